// File: rtl/softbit_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : softbit_frame_loader
// Brief    : Packs a serial stream of soft symbols into one 24-bit word per
//            trellis step and writes the words into the decoder input SRAM.
//            It then launches the core and keeps the buffer untouched until
//            the core reports frame_done, because the core re-reads it
//            during the tail-biting wrap.
// Revision : 1.0 - initial release
// ============================================================================
module softbit_frame_loader #(
  parameter int SRC_ADDR_W = 12,
  parameter int SB_W       = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_an_i,
  input  logic                  rst_sync_i,
  input  logic                  start_i,
  input  logic [2:0]            sym_per_step_i,
  input  logic [11:0]           word_count_i,
  input  logic [SRC_ADDR_W-1:0] base_addr_i,
  input  logic                  sb_valid_i,
  input  logic [SB_W-1:0]       sb_data_i,
  output logic                  sb_ready_o,
  output logic                  wr_o,
  output logic [SRC_ADDR_W-1:0] addr_o,
  output logic [6*SB_W-1:0]     wdata_o,
  output logic                  frame_start_o,
  input  logic                  core_busy_i,
  input  logic                  core_done_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  cfg_err_o
);

  localparam int LANES  = 6;
  localparam int WORD_W = LANES * SB_W;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FILL      = 3'd1,
    ST_FLUSH     = 3'd2,
    ST_LAUNCH    = 3'd3,
    ST_WAIT_DONE = 3'd4
  } state_t;

  state_t                  state_q;
  logic [2:0]              nsym_q;
  logic [11:0]             wcnt_q;
  logic [SRC_ADDR_W-1:0]   base_q;
  logic [2:0]              lane_q;
  logic [11:0]             widx_q;
  logic [WORD_W-1:0]       pack_q;
  logic                    wr_q;
  logic [SRC_ADDR_W-1:0]   addr_q;
  logic [WORD_W-1:0]       wdata_q;
  logic                    fs_q;
  logic                    done_q;
  logic                    cfg_err_q;

  logic                    sym_accept;
  logic                    last_lane;
  logic                    last_word;
  logic                    cfg_legal;
  logic [WORD_W-1:0]       pack_d;
  logic [SRC_ADDR_W-1:0]   addr_d;

  assign sb_ready_o    = (state_q == ST_FILL);
  assign busy_o        = (state_q != ST_IDLE);
  assign wr_o          = wr_q;
  assign addr_o        = addr_q;
  assign wdata_o       = wdata_q;
  assign frame_start_o = fs_q;
  assign done_o        = done_q;
  assign cfg_err_o     = cfg_err_q;

  assign sym_accept = sb_valid_i & sb_ready_o;
  assign last_lane  = (lane_q == (nsym_q - 3'd1));
  assign last_word  = (widx_q == (wcnt_q - 12'd1));
  assign cfg_legal  = (sym_per_step_i != 3'd0) && (sym_per_step_i != 3'd7) &&
                      (word_count_i != 12'd0);
  // Address arithmetic is modulo the SRAM depth, so a frame may wrap past the top.
  assign addr_d     = base_q + SRC_ADDR_W'(widx_q);

  // Current word with the incoming symbol dropped into its lane; the
  // accumulator is cleared per word, so lanes beyond N stay zero.
  always_comb begin
    pack_d = pack_q;
    for (int l = 0; l < LANES; l++) begin
      if (lane_q == 3'(l)) begin
        pack_d[l*SB_W +: SB_W] = sb_data_i;
      end
    end
  end

  // Frame sequencer: config latch, lane packing, SRAM write, launch and done handshake.
  always_ff @(posedge clk_i or negedge rst_an_i) begin
    if (!rst_an_i) begin
      state_q   <= ST_IDLE;
      nsym_q    <= 3'd0;
      wcnt_q    <= 12'd0;
      base_q    <= '0;
      lane_q    <= 3'd0;
      widx_q    <= 12'd0;
      pack_q    <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      fs_q      <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else if (rst_sync_i) begin
      state_q   <= ST_IDLE;
      nsym_q    <= 3'd0;
      wcnt_q    <= 12'd0;
      base_q    <= '0;
      lane_q    <= 3'd0;
      widx_q    <= 12'd0;
      pack_q    <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      fs_q      <= 1'b0;
      done_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      fs_q   <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            if (cfg_legal) begin
              nsym_q    <= sym_per_step_i;
              wcnt_q    <= word_count_i;
              base_q    <= base_addr_i;
              lane_q    <= 3'd0;
              widx_q    <= 12'd0;
              pack_q    <= '0;
              cfg_err_q <= 1'b0;
              state_q   <= ST_FILL;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        ST_FILL: begin
          if (sym_accept) begin
            if (last_lane) begin
              wr_q    <= 1'b1;
              addr_q  <= addr_d;
              wdata_q <= pack_d;
              pack_q  <= '0;
              lane_q  <= 3'd0;
              widx_q  <= widx_q + 12'd1;
              if (last_word) begin
                state_q <= ST_FLUSH;
              end
            end else begin
              pack_q <= pack_d;
              lane_q <= lane_q + 3'd1;
            end
          end
        end
        // The launch decision is already taken while the final write is on
        // the bus, so an idle core sees frame_start one cycle after it.
        ST_FLUSH, ST_LAUNCH: begin
          if (!core_busy_i) begin
            fs_q    <= 1'b1;
            state_q <= ST_WAIT_DONE;
          end else begin
            state_q <= ST_LAUNCH;
          end
        end
        ST_WAIT_DONE: begin
          if (core_done_i) begin
            done_q  <= 1'b1;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_softbit_frame_loader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_softbit_frame_loader
// Brief    : Directed, table-driven bench for softbit_frame_loader.
// Revision : 1.0 - initial release
// ============================================================================
module tb_softbit_frame_loader;

  logic        clk_i = 1'b0;
  logic        rst_an_i = 1'b0;
  logic        rst_sync_i = 1'b0;
  logic        start_i = 1'b0;
  logic [2:0]  sym_per_step_i = 3'd0;
  logic [11:0] word_count_i = 12'd0;
  logic [11:0] base_addr_i = 12'd0;
  logic        sb_valid_i = 1'b0;
  logic [3:0]  sb_data_i = 4'd0;
  logic        core_busy_i = 1'b0;
  logic        core_done_i = 1'b0;
  logic        sb_ready_o;
  logic        wr_o;
  logic [11:0] addr_o;
  logic [23:0] wdata_o;
  logic        frame_start_o;
  logic        busy_o;
  logic        done_o;
  logic        cfg_err_o;

  softbit_frame_loader #(.SRC_ADDR_W(12), .SB_W(4)) dut (
    .clk_i(clk_i), .rst_an_i(rst_an_i), .rst_sync_i(rst_sync_i),
    .start_i(start_i), .sym_per_step_i(sym_per_step_i),
    .word_count_i(word_count_i), .base_addr_i(base_addr_i),
    .sb_valid_i(sb_valid_i), .sb_data_i(sb_data_i), .sb_ready_o(sb_ready_o),
    .wr_o(wr_o), .addr_o(addr_o), .wdata_o(wdata_o),
    .frame_start_o(frame_start_o), .core_busy_i(core_busy_i),
    .core_done_i(core_done_i), .busy_o(busy_o), .done_o(done_o),
    .cfg_err_o(cfg_err_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    logic [11:0] addr;
    logic [23:0] data;
    int          cyc;
  } wr_rec_t;

  wr_rec_t wr_log[$];
  int      fs_log[$];

  // Write and launch monitor, sampled on the falling edge.
  always @(negedge clk_i) begin
    if (wr_o) wr_log.push_back('{addr_o, wdata_o, cyc});
    if (frame_start_o) fs_log.push_back(cyc);
  end

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic do_start(input logic [2:0] n, input logic [11:0] wc, input logic [11:0] base);
    sym_per_step_i = n;
    word_count_i   = wc;
    base_addr_i    = base;
    start_i        = 1'b1;
    tick();
    start_i        = 1'b0;
    sym_per_step_i = 3'd0;
    word_count_i   = 12'd0;
    base_addr_i    = 12'hAAA;
  endtask

  logic [3:0] sym_tab [6];

  // mode 0: symbol k is (k+1) mod 16; mode 1: symbols from sym_tab.
  task automatic feed(input int total, input int mode, input bit gaps, output int last_acc);
    last_acc = 0;
    for (int k = 0; k < total; k++) begin
      int budget;
      bit ok;
      if (gaps) begin
        sb_valid_i = 1'b0;
        sb_data_i  = 4'hF;
        tick();
      end
      sb_valid_i = 1'b1;
      sb_data_i  = (mode == 0) ? 4'((k + 1) % 16) : sym_tab[k % 6];
      budget = 0;
      ok     = 1'b0;
      while (!ok && budget < 20) begin
        ok       = sb_ready_o;
        last_acc = cyc;
        tick();
        budget++;
      end
      if (!ok) begin
        n_assert++;
        n_fail++;
        $display("FAIL feed_timeout: symbol %0d not accepted within 20 cycles", k);
        break;
      end
    end
    sb_valid_i = 1'b0;
  endtask

  task automatic finish_frame(input string tag);
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    chk({tag, "_done"}, done_o, 1);
    chk({tag, "_busy_after_done"}, busy_o, 0);
    tick();
    chk({tag, "_done_pulse_len"}, done_o, 0);
  endtask

  typedef struct {
    logic [2:0]  n;
    logic [11:0] base;
    logic [23:0] syms;      // symbols in arrival order, first in bits [23:20]
    logic [23:0] exp_data;
  } pack_vec_t;

  pack_vec_t vecs[6];

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int bad;
    int fall;
    logic [23:0] e;

    vecs[0] = '{3'd6, 12'h123, 24'hFEDCBA, 24'hABCDEF};
    vecs[1] = '{3'd2, 12'h000, 24'h780000, 24'h000087};
    vecs[2] = '{3'd1, 12'hFFF, 24'h500000, 24'h000005};
    vecs[3] = '{3'd3, 12'h010, 24'h123000, 24'h000321};
    vecs[4] = '{3'd4, 12'h7FF, 24'h90AB00, 24'h00BA09};
    vecs[5] = '{3'd5, 12'h456, 24'h123450, 24'h054321};

    // ---------------- reset values ----------------
    tick(); tick();
    chk("rst_sb_ready", sb_ready_o, 0);
    chk("rst_wr", wr_o, 0);
    chk("rst_frame_start", frame_start_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_cfg_err", cfg_err_o, 0);
    chk("rst_addr", addr_o, 0);
    chk("rst_wdata", wdata_o, 0);
    rst_an_i = 1'b1;
    tick();

    // core_done outside WAIT_DONE is ignored
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    chk("idle_done_ignored", done_o, 0);

    // ---------------- single full frame ----------------
    wr_log.delete(); fs_log.delete();
    do_start(3'd3, 12'h9E8, 12'h000);
    chk("full_start_busy", busy_o, 1);
    chk("full_start_ready", sb_ready_o, 1);
    feed(3 * 12'h9E8, 0, 1'b0, acc);
    chk("full_ready_after_last", sb_ready_o, 0);
    tick(); tick(); tick();
    chk("full_write_count", wr_log.size(), 12'h9E8);
    if (wr_log.size() == 12'h9E8) begin
      bad = 0;
      for (int i = 0; i < wr_log.size(); i++) begin
        e = {12'h000, 4'((3 * i + 3) % 16), 4'((3 * i + 2) % 16), 4'((3 * i + 1) % 16)};
        if (wr_log[i].addr !== 12'(i) || wr_log[i].data !== e) bad++;
      end
      chk("full_bad_words", bad, 0);
      chk("full_word0", wr_log[0].data, 24'h000321);
      chk("full_last_addr", wr_log[12'h9E7].addr, 12'h9E7);
      chk("full_write_latency", wr_log[12'h9E7].cyc, acc + 1);
      chk("full_fs_count", fs_log.size(), 1);
      if (fs_log.size() == 1)
        chk("full_fs_timing", fs_log[0], wr_log[12'h9E7].cyc + 1);
    end
    finish_frame("full");

    // ---------------- address wrap / back-to-back ----------------
    wr_log.delete(); fs_log.delete();
    do_start(3'd1, 12'd4, 12'hFFE);
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
    chk("fill_done_ignored", done_o, 0);
    chk("fill_busy_kept", busy_o, 1);
    feed(4, 0, 1'b0, acc);
    tick(); tick(); tick();
    chk("wrap_count", wr_log.size(), 4);
    if (wr_log.size() == 4) begin
      chk("wrap_addr0", wr_log[0].addr, 12'hFFE);
      chk("wrap_addr1", wr_log[1].addr, 12'hFFF);
      chk("wrap_addr2", wr_log[2].addr, 12'h000);
      chk("wrap_addr3", wr_log[3].addr, 12'h001);
      chk("wrap_data2", wr_log[2].data, 24'h000003);
      chk("wrap_back_to_back", wr_log[3].cyc - wr_log[0].cyc, 3);
    end
    chk("wrap_fs_count", fs_log.size(), 1);
    finish_frame("wrap");

    // ---------------- lane packing table (with valid gaps) ----------------
    for (int i = 0; i < 6; i++) begin
      wr_log.delete(); fs_log.delete();
      for (int k = 0; k < 6; k++) sym_tab[k] = 4'(vecs[i].syms >> (20 - 4 * k));
      do_start(vecs[i].n, 12'd1, vecs[i].base);
      feed(int'(vecs[i].n), 1, 1'b1, acc);
      tick(); tick(); tick();
      chk($sformatf("vec%0d_count", i), wr_log.size(), 1);
      if (wr_log.size() == 1) begin
        chk($sformatf("vec%0d_wdata", i), wr_log[0].data, vecs[i].exp_data);
        chk($sformatf("vec%0d_addr", i), wr_log[0].addr, vecs[i].base);
      end
      chk($sformatf("vec%0d_fs", i), fs_log.size(), 1);
      finish_frame($sformatf("vec%0d", i));
    end

    // ---------------- busy hold-off ----------------
    wr_log.delete(); fs_log.delete();
    core_busy_i = 1'b1;
    do_start(3'd2, 12'd3, 12'h200);
    feed(6, 0, 1'b0, acc);
    repeat (50) tick();
    chk("hold_no_fs", fs_log.size(), 0);
    chk("hold_busy", busy_o, 1);
    chk("hold_count", wr_log.size(), 3);
    if (wr_log.size() == 3) chk("hold_word2", wr_log[2].data, 24'h000065);
    core_busy_i = 1'b0;
    fall = cyc;
    tick(); tick();
    chk("hold_fs_count", fs_log.size(), 1);
    if (fs_log.size() == 1) chk("hold_fs_timing", fs_log[0], fall + 1);
    finish_frame("hold");

    // ---------------- illegal config ----------------
    wr_log.delete(); fs_log.delete();
    do_start(3'd7, 12'd5, 12'h000);
    chk("ill_n7_err", cfg_err_o, 1);
    chk("ill_n7_ready", sb_ready_o, 0);
    chk("ill_n7_busy", busy_o, 0);
    tick();
    do_start(3'd3, 12'd0, 12'h000);
    chk("ill_wc0_err", cfg_err_o, 1);
    chk("ill_wc0_ready", sb_ready_o, 0);
    tick();
    do_start(3'd0, 12'd5, 12'h000);
    chk("ill_n0_err", cfg_err_o, 1);
    chk("ill_n0_busy", busy_o, 0);
    tick();
    do_start(3'd2, 12'd1, 12'h300);
    chk("legal_clears_err", cfg_err_o, 0);
    chk("legal_ready", sb_ready_o, 1);
    sym_tab[0] = 4'h7; sym_tab[1] = 4'h8;
    feed(2, 1, 1'b0, acc);
    tick(); tick(); tick();
    chk("legal_count", wr_log.size(), 1);
    if (wr_log.size() == 1) begin
      chk("legal_wdata", wr_log[0].data, 24'h000087);
      chk("legal_addr", wr_log[0].addr, 12'h300);
    end
    finish_frame("legal");

    // ---------------- abort mid-frame ----------------
    wr_log.delete(); fs_log.delete();
    do_start(3'd1, 12'd200, 12'h100);
    sym_per_step_i = 3'd2; word_count_i = 12'd7; base_addr_i = 12'h555;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    feed(100, 0, 1'b0, acc);
    rst_sync_i = 1'b1;
    tick();
    rst_sync_i = 1'b0;
    chk("abort_busy", busy_o, 0);
    chk("abort_ready", sb_ready_o, 0);
    chk("abort_wr", wr_o, 0);
    repeat (10) tick();
    chk("abort_count", wr_log.size(), 100);
    if (wr_log.size() == 100) begin
      chk("abort_first_addr", wr_log[0].addr, 12'h100);
      chk("abort_last_addr", wr_log[99].addr, 12'h163);
      chk("abort_last_data", wr_log[99].data, 24'h000004);
    end
    chk("abort_no_fs", fs_log.size(), 0);
    wr_log.delete();
    do_start(3'd1, 12'd2, 12'h100);
    feed(2, 0, 1'b0, acc);
    tick(); tick(); tick();
    chk("restart_count", wr_log.size(), 2);
    if (wr_log.size() == 2) chk("restart_addr", wr_log[0].addr, 12'h100);
    chk("restart_fs", fs_log.size(), 1);
    finish_frame("restart");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/softbit_frame_loader.md
# softbit_frame_loader

Upstream feeder for `viterbi_core`. Accepts a serial stream of 4-bit soft symbols and packs one trellis step (1–6 symbols) into each 24-bit word. Writes the packed words into the 24x4096 input SRAM, then issues `frame_start` to the core. It holds the buffer untouched until the core reports `frame_done`, because the core re-reads the buffer during tail-biting wrap.

## Interface
Parameters:
- `SRC_ADDR_W`, 12: input SRAM address width.
- `SB_W`, 4: soft-symbol width. Lanes are packed `6*SB_W` = 24 bits.

Ports:
- `clk_i`  in  1  clock.
- `rst_an_i`  in  1  asynchronous, active-low reset.
- `rst_sync_i`  in  1  synchronous clear, active-high. Same effect as reset.
- `start_i`  in  1  arm loading of one frame. Sampled in IDLE only.
- `sym_per_step_i`  in  3  symbols per trellis step, legal 1..6.
- `word_count_i`  in  12  words (trellis steps) per frame, legal 1..4095.
- `base_addr_i`  in  SRC_ADDR_W  first SRAM address.
- `sb_valid_i`  in  1  soft symbol valid.
- `sb_data_i`  in  SB_W  soft symbol.
- `sb_ready_o`  out  1  loader accepts a symbol.
- `wr_o`  out  1  SRAM write enable.
- `addr_o`  out  SRC_ADDR_W  SRAM write address.
- `wdata_o`  out  24  packed word.
- `frame_start_o`  out  1  one-cycle pulse to the core.
- `core_busy_i`  in  1  core `busy_o`.
- `core_done_i`  in  1  core `frame_done_o`.
- `busy_o`  out  1  high in any state other than IDLE.
- `done_o`  out  1  one-cycle pulse when the core finishes this frame.
- `cfg_err_o`  out  1  sticky illegal-config flag. Cleared by the next legal `start_i` or by reset.

## Operation
- States: IDLE, FILL, FLUSH, LAUNCH, WAIT_DONE.
- **IDLE:**
  - `start_i` with legal config: latch `sym_per_step_i`, `word_count_i` and `base_addr_i`, clear counters, go to FILL.
  - `start_i` with illegal config (`sym_per_step_i` 0 or 7, or `word_count_i` 0): set `cfg_err_o`, stay in IDLE.
- **FILL:**
  - `sb_ready_o`=1. A symbol transfers on `sb_valid_i & sb_ready_o`.
  - Lane counter `lane` runs 0..N-1. The symbol goes to bits `[4*lane+3:4*lane]`.
  - On the Nth symbol: the word is registered, with unused lanes forced to 0, and written the next cycle.
  - `lane` resets to 0 and the word index increments.
- **Write address:** `addr_o = base + word_idx`, modulo 2^SRC_ADDR_W. The address wraps 4095→0.
- **FILL → FLUSH:** when the final word's last symbol is accepted. `sb_ready_o`=0 from the next cycle.
- **FLUSH:** the final word's write is performed this cycle. Go to LAUNCH.
- **LAUNCH:**
  - Wait while `core_busy_i`=1.
  - When `core_busy_i`=0: pulse `frame_start_o` for one cycle and go to WAIT_DONE.
- **WAIT_DONE:**
  - `core_done_i`=1 → pulse `done_o` the next cycle, go to IDLE.
  - `core_done_i` is ignored in every other state.
- `start_i` outside IDLE is ignored.
- Reset or `rst_sync_i` mid-frame abandons the frame: return to IDLE, no further writes, no `frame_start_o`.

## Timing
- **Reset values:** `sb_ready_o`, `wr_o`, `frame_start_o`, `busy_o`, `done_o` and `cfg_err_o` = 0. `addr_o`=0, `wdata_o`=0.
- **Start:** `start_i` at cycle t → `busy_o`=1 and `sb_ready_o`=1 at t+1.
- **Write latency:** last symbol of a word accepted at cycle c → `wr_o`=1 at c+1 with the full word and address. `wr_o` is never high for two words in the same cycle.
- **Back-to-back words:** when N=1 and `sb_valid_i` is held high, `wr_o` is high every cycle.
- **Launch:** final write at cycle f → `frame_start_o` at f+1 at the earliest. It is later if `core_busy_i` is high, and fires on the first cycle after `core_busy_i` falls.
- **Done:** `core_done_i` at cycle d → `done_o` at d+1 and `busy_o`=0 at d+1.
- **Stalls:** `sb_valid_i` gaps stall the lane counter. A partial word is held indefinitely.

## Test plan
- **Single full frame:** N=3, `word_count`=0x9E8, base 0, stream symbols 1,2,3,… → 0x9E8 writes at addresses 0..0x9E7. Word0 `wdata`=0x000321. `frame_start_o` fires once, 1 cycle after the last write.
- **Wrap:** base 0xFFE, N=1, `word_count`=4 → addresses 0xFFE, 0xFFF, 0x000, 0x001.
- **Lane packing:** N=6, symbols F,E,D,C,B,A → `wdata`=0xABCDEF. N=2, symbols 7,8 → 0x000087.
- **Busy hold-off:** `core_busy_i` held high for 50 cycles after the final write → `frame_start_o` appears 1 cycle after the fall. `core_done_i` pulse → `done_o` the next cycle, `busy_o`=0.
- **Illegal config:** `start_i` with N=7, then with `word_count`=0 → `cfg_err_o`=1, no `sb_ready_o`. A following legal `start_i` clears `cfg_err_o` and loads normally.
- **Abort:** `rst_sync_i` after 100 of 200 words → state IDLE the next cycle, `wr_o`=0, no `frame_start_o`. A new `start_i` restarts at base.
